// File: rtl/item_serializer.sv
// item_serializer: accepts one wide word of ITEM_COUNT packed items per
// handshake and emits the items one per beat (item 0 first) on a narrow
// stream.
// The final beat of each word can overlap with accepting the next word,
// so back-to-back words stream without an idle cycle.
// Optional build macro ITEM_SERIALIZER_COUNT_EN adds an in_count port.
// in_count gives the number of valid items in the word; a value of 0
// means all ITEM_COUNT items are valid.
module item_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int ITEM_COUNT = 3
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [DATA_WIDTH*ITEM_COUNT-1:0] in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_last,
`ifdef ITEM_SERIALIZER_COUNT_EN
  input  logic [$clog2(ITEM_COUNT+1)-1:0]  in_count,
`endif
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_last
);

  localparam int IDX_W = (ITEM_COUNT > 1) ? $clog2(ITEM_COUNT) : 1;
  localparam int CNT_W = $clog2(ITEM_COUNT + 1);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                         state_q, state_d;
  logic [DATA_WIDTH*ITEM_COUNT-1:0] word_q;
  logic [IDX_W-1:0]               index_q, index_d;
  logic [IDX_W-1:0]               final_q, final_d;
  logic                           last_q;
  logic                           at_final;
  logic                           accept;
  logic [DATA_WIDTH-1:0]          item;

  assign at_final = (index_q == final_q);
  assign accept   = in_valid & in_ready;

  // Index of the last item to emit for the word being offered.
`ifdef ITEM_SERIALIZER_COUNT_EN
  always_comb begin
    final_d = IDX_W'(ITEM_COUNT - 1);
    if (in_count != '0 && in_count <= CNT_W'(ITEM_COUNT))
      final_d = IDX_W'(in_count - 1'b1);
  end
`else
  assign final_d = IDX_W'(ITEM_COUNT - 1);
`endif

  // Handshake and stream outputs, all forced low while reset is held.
  always_comb begin
    in_ready  = !reset & ((state_q == IDLE) |
                          ((state_q == EMIT) & at_final & out_ready));
    out_valid = !reset & (state_q == EMIT);
    out_last  = out_valid & last_q & at_final;
    out_data  = reset ? '0 : item;
  end

  // Select item index_q out of the held word.
  always_comb begin
    item = '0;
    for (int k = 0; k < ITEM_COUNT; k++) begin
      if (index_q == IDX_W'(k))
        item = word_q[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next-state logic: advance through the word, reload or go idle.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    state_d = state_q;
    index_d = index_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = EMIT;
      end
      EMIT: begin
        if (out_ready) begin
          if (!at_final)   index_d = index_q + 1'b1;
          else if (accept) state_d = EMIT;
          else             state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) index_d = '0;
  end

  // State register with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q <= IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Word, last flag and final index are captured on every accepted word.
  always_ff @(posedge clock) begin
    // NOTE: the word register is cleared on reset so out_data starts from a
    // known value; it is a plain register, not a RAM, so this is cheap.
    if (reset) begin
      word_q  <= '0;
      last_q  <= 1'b0;
      final_q <= IDX_W'(ITEM_COUNT - 1);
    end else if (accept) begin
      word_q  <= in_data;
      last_q  <= in_last;
      final_q <= final_d;
    end
  end

endmodule

// File: tb/tb_item_serializer.sv
// tb_item_serializer: directed test of item_serializer with DATA_WIDTH=8 and
// ITEM_COUNT=3.
// Inputs change 1 ns after each rising edge; outputs are checked on the
// falling edge.
// Define ITEM_SERIALIZER_COUNT_EN to also exercise the in_count port.
module tb_item_serializer;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
`ifdef ITEM_SERIALIZER_COUNT_EN
  logic [1:0]  in_count;
`endif
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int passed = 0;
  int total  = 0;

  always #5 clock = ~clock;

  item_serializer #(.DATA_WIDTH(8), .ITEM_COUNT(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
`ifdef ITEM_SERIALIZER_COUNT_EN
    .in_count  (in_count),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for the falling edge, then compare all stream outputs.
  task automatic expect_out(input string tag, input logic v, input logic [7:0] d,
                            input logic l, input logic r);
    @(negedge clock);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    if (v) check({tag, ".out_data"}, 32'(out_data), 32'(d));
    check({tag, ".out_last"}, 32'(out_last), 32'(l));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(r));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic       bp_ready [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] bp_data  [6] = '{8'h11, 8'h22, 8'h22, 8'h22, 8'h33, 8'h33};

  initial begin
    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
`ifdef ITEM_SERIALIZER_COUNT_EN
    in_count  = 2'd0;
`endif

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("rst.out_valid", 32'(out_valid), 32'd0);
      check("rst.in_ready", 32'(in_ready), 32'd0);
      check("rst.out_data", 32'(out_data), 32'd0);
      tick();
    end
    reset = 1'b0;
    expect_out("post_rst", 1'b0, 8'h00, 1'b0, 1'b1);

    // Single word, downstream always ready.
    in_data = 24'h332211; in_last = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_out("single0", 1'b1, 8'h11, 1'b0, 1'b0); tick();
    expect_out("single1", 1'b1, 8'h22, 1'b0, 1'b0); tick();
    expect_out("single2", 1'b1, 8'h33, 1'b1, 1'b1); tick();
    expect_out("single_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    // Back-to-back words with in_valid held high.
    in_data = 24'h030201; in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_data = 24'h060504; in_last = 1'b1;
    expect_out("b2b01", 1'b1, 8'h01, 1'b0, 1'b0); tick();
    expect_out("b2b02", 1'b1, 8'h02, 1'b0, 1'b0); tick();
    expect_out("b2b03", 1'b1, 8'h03, 1'b0, 1'b1); tick();
    in_valid = 1'b0;
    expect_out("b2b04", 1'b1, 8'h04, 1'b0, 1'b0); tick();
    expect_out("b2b05", 1'b1, 8'h05, 1'b0, 1'b0); tick();
    expect_out("b2b06", 1'b1, 8'h06, 1'b1, 1'b1); tick();
    expect_out("b2b_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    // Backpressure: out_ready pattern 1,0,0,1,0,1.
    in_data = 24'h332211; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_ready = bp_ready[i];
      expect_out($sformatf("bp%0d", i), 1'b1, bp_data[i],
                 bp_data[i] == 8'h33, i == 5);
      tick();
    end
    out_ready = 1'b1;
    expect_out("bp_idle", 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset after the first item has been taken downstream.
    in_data = 24'h332211; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_out("mid0", 1'b1, 8'h11, 1'b0, 1'b0); tick();
    reset = 1'b1;
    expect_out("mid_rst", 1'b0, 8'h00, 1'b0, 1'b0);
    check("mid_rst.out_data", 32'(out_data), 32'd0);
    tick();
    reset = 1'b0;
    expect_out("mid_idle", 1'b0, 8'h00, 1'b0, 1'b1);
    in_data = 24'hAABBCC; in_last = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    expect_out("mid_cc", 1'b1, 8'hCC, 1'b0, 1'b0); tick();
    expect_out("mid_bb", 1'b1, 8'hBB, 1'b0, 1'b0); tick();
    expect_out("mid_aa", 1'b1, 8'hAA, 1'b1, 1'b1); tick();
    expect_out("mid_end", 1'b0, 8'h00, 1'b0, 1'b1);

`ifdef ITEM_SERIALIZER_COUNT_EN
    // Partial word: only two items valid.
    in_data = 24'h332211; in_last = 1'b1; in_count = 2'd2; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; in_count = 2'd0;
    expect_out("cnt0", 1'b1, 8'h11, 1'b0, 1'b0); tick();
    expect_out("cnt1", 1'b1, 8'h22, 1'b1, 1'b1); tick();
    expect_out("cnt_idle", 1'b0, 8'h00, 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
